// File: rtl/cpu_io_pkg.sv
// Shared definitions for the CPU result display: status-word bit layout,
// capture counter width and display mode encoding.
package cpu_io_pkg;

    localparam int ZF_BIT           = 0;
    localparam int OF_BIT           = 1;
    localparam int STATUS_FLAG_BITS = 2;
    localparam int CAP_CNT_W        = 8;

    typedef logic [CAP_CNT_W-1:0] cap_cnt_t;

    typedef enum logic {
        DISP_SLICE  = 1'b0,
        DISP_STATUS = 1'b1
    } disp_mode_e;

    function automatic cap_cnt_t cap_cnt_next(input cap_cnt_t cnt);
        return cnt + cap_cnt_t'(1);
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser followed by a stability filter: dout only follows a
// synchronised value that differs from it and stays unchanged for DB_CYCLES samples.
module sw_debounce #(
    parameter int WIDTH     = 2,
    parameter int DB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_cand;
    logic [WIDTH-1:0] r_dout;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_run;

    // Length of the current run of identical samples, including this one
    always_comb begin
        w_run = CNT_W'(1);
        if ((r_cnt != '0) && (r_sync2 == r_cand)) begin
            w_run = r_cnt + CNT_W'(1);
        end else begin
            w_run = CNT_W'(1);
        end
    end

    // Synchroniser, run counter and accepted output
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_cand  <= '0;
            r_dout  <= '0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_dout) begin
                r_cnt <= '0;
            end else if (w_run >= CNT_W'(DB_CYCLES)) begin
                r_dout <= r_sync2;
                r_cnt  <= '0;
            end else begin
                r_cnt  <= w_run;
                r_cand <= r_sync2;
            end
        end
    end

    assign dout = r_dout;

endmodule

// File: rtl/result_led_ctrl.sv
// Captures CPU results with their flags and shows either one LED_W-wide slice
// of the held word or a status word (capture count and flags) on the LED bank.
module result_led_ctrl
    import cpu_io_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int LED_W     = 8,
    parameter int SEL_W     = 2,
    parameter int DB_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SEL_W-1:0]  sw,
    input  logic [DATA_W-1:0] result,
    input  logic              result_vld,
    input  logic              zf_in,
    input  logic              of_in,
    input  logic              clr_flags,
    output logic [LED_W-1:0]  led,
    output logic              ZF,
    output logic              OF,
    output logic              of_sticky,
    output logic [SEL_W-1:0]  sel_q
);

    localparam int NSLICE = DATA_W / LED_W;
    localparam int NSEL   = 2 ** SEL_W;

    logic [DATA_W-1:0] r_hold;
    logic              r_zf;
    logic              r_of;
    logic              r_sticky;
    cap_cnt_t          r_cap_cnt;
    logic [LED_W-1:0]  r_led;

    logic [SEL_W-1:0]  w_sel;
    logic [LED_W-1:0]  w_slices [NSEL];
    logic [LED_W-1:0]  w_status;
    logic [LED_W-1:0]  w_led_next;
    disp_mode_e        w_mode;
    logic              w_cap_unused;

    sw_debounce #(
        .WIDTH     (SEL_W),
        .DB_CYCLES (DB_CYCLES)
    ) u_sw_debounce (
        .clk  (clk),
        .rst  (rst),
        .din  (sw),
        .dout (w_sel)
    );

    // Selector codes beyond the last slice read as zero; they display status instead
    for (genvar g = 0; g < NSEL; g++) begin : g_slice
        if (g < NSLICE) begin : g_real
            assign w_slices[g] = r_hold[g*LED_W +: LED_W];
        end else begin : g_none
            assign w_slices[g] = '0;
        end
    end

    for (genvar g = 0; g < LED_W; g++) begin : g_status
        if (g == ZF_BIT) begin : g_zf
            assign w_status[g] = r_zf;
        end else if (g == OF_BIT) begin : g_of
            assign w_status[g] = r_of;
        end else if ((g - STATUS_FLAG_BITS) < CAP_CNT_W) begin : g_cnt
            assign w_status[g] = r_cap_cnt[g-STATUS_FLAG_BITS];
        end else begin : g_pad
            assign w_status[g] = 1'b0;
        end
    end

    assign w_cap_unused = ^r_cap_cnt;

    // Display source selection
    always_comb begin
        w_mode     = DISP_STATUS;
        w_led_next = '0;
        if (int'(w_sel) < NSLICE) begin
            w_mode = DISP_SLICE;
        end else begin
            w_mode = DISP_STATUS;
        end
        case (w_mode)
            DISP_SLICE:  w_led_next = w_slices[w_sel];
            DISP_STATUS: w_led_next = w_status;
            default:     w_led_next = '0;
        endcase
    end

    // Result capture, flags, capture counter and registered LED value
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hold    <= '0;
            r_zf      <= 1'b0;
            r_of      <= 1'b0;
            r_sticky  <= 1'b0;
            r_cap_cnt <= '0;
            r_led     <= '0;
        end else begin
            r_led <= w_led_next;
            if (result_vld) begin
                r_hold    <= result;
                r_zf      <= zf_in;
                r_of      <= of_in;
                r_cap_cnt <= cap_cnt_next(r_cap_cnt);
            end else begin
                r_hold    <= r_hold;
                r_zf      <= r_zf;
                r_of      <= r_of;
                r_cap_cnt <= r_cap_cnt;
            end
            // A new overflow outranks a concurrent clear
            if (result_vld && of_in) begin
                r_sticky <= 1'b1;
            end else if (clr_flags) begin
                r_sticky <= 1'b0;
            end else begin
                r_sticky <= r_sticky;
            end
        end
    end

    assign led       = r_led;
    assign ZF        = r_zf;
    assign OF        = r_of;
    assign of_sticky = r_sticky;
    assign sel_q     = w_sel;

endmodule

// File: doc/result_led_ctrl.md
RESULT_LED_CTRL -- requirements
Module: result_led_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, width of the result word to display.
REQ-002 Parameter LED_W, default 8, LED bank width; DATA_W SHALL be an integer multiple of LED_W.
REQ-003 Parameter SEL_W, default 2, switch width; NSLICE = DATA_W/LED_W SHALL be <= 2^SEL_W.
REQ-004 Parameter DB_CYCLES, default 4, number of consecutive stable samples required to accept a switch change (>=1).
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-low.
REQ-007 sw  input  SEL_W  raw slice-select switches, asynchronous to clk.
REQ-008 result  input  DATA_W  CPU result word.
REQ-009 result_vld  input  1  single-cycle strobe qualifying result, zf_in, of_in.
REQ-010 zf_in  input  1  zero flag accompanying result.
REQ-011 of_in  input  1  overflow flag accompanying result.
REQ-012 clr_flags  input  1  clears sticky overflow.
REQ-013 led  output  LED_W  registered display value.
REQ-014 ZF  output  1  zero flag of last captured result.
REQ-015 OF  output  1  overflow flag of last captured result.
REQ-016 of_sticky  output  1  set by any captured overflow until cleared.
REQ-017 sel_q  output  SEL_W  debounced slice select currently in use.

Function
REQ-018 sw SHALL pass through a 2-flop synchroniser before any use.
REQ-019 sel_q SHALL take the synchronised value only after that value differs from sel_q and has been identical for DB_CYCLES consecutive cycles; any change restarts the count.
REQ-020 On result_vld, hold register, ZF and OF SHALL load result, zf_in, of_in at that edge (1-cycle latency); without result_vld they SHALL hold.
REQ-021 An 8-bit capture counter SHALL increment on each result_vld, wrapping 255 -> 0.
REQ-022 For sel_q < NSLICE, led SHALL register hold[sel_q*LED_W +: LED_W]; slice 0 is least significant.
REQ-023 For sel_q >= NSLICE (status mode), led SHALL register {capture counter low LED_W-2 bits, OF, ZF}, ZF in bit 0.
REQ-024 led SHALL therefore reflect a new result 2 cycles after result_vld and a new sel_q 1 cycle after sel_q changes.
REQ-025 of_sticky SHALL set on result_vld with of_in=1 and clear on clr_flags; simultaneous set and clear SHALL leave it set.
REQ-026 result, zf_in, of_in SHALL be ignored when result_vld=0.

Reset
REQ-027 While rst=0 at a rising edge: led, ZF, OF, of_sticky, sel_q, hold, capture counter, debounce counter and synchroniser flops SHALL go to 0.
REQ-028 A result_vld coincident with active reset SHALL be discarded; reset mid-debounce SHALL abandon the pending switch change.

Structure
REQ-029 Debounce logic SHALL be a sub-module sw_debounce (parameters WIDTH, DB_CYCLES; ports clk, rst, din, dout).
REQ-030 Status-mode bit positions (ZF=0, OF=1) and capture-counter width (8) SHALL live in a shared package cpu_io_pkg.
REQ-031 No latches, no combinational path from any input to any output.

Verification
REQ-032 Reset: rst=0 for 2 cycles with result_vld=1, result=32'hFFFF_FFFF -> all outputs 0 after release.
REQ-033 Capture: sw=0 stable, result=32'h1234_5678 with result_vld pulse -> led=8'h78 two cycles later; sw=3 stable -> led=8'h12 at 2+DB_CYCLES+1 cycles after change.
REQ-034 Debounce: sw toggles 0->1->0 with 3-cycle glitches (DB_CYCLES=4) -> sel_q stays 0; sw=1 held 6 cycles -> sel_q=1.
REQ-035 Status mode (DATA_W=16, LED_W=8, SEL_W=2): sw=2, three result_vld pulses last with zf_in=1, of_in=1 -> led=8'b0000_1111.
REQ-036 Sticky: of_in=1 capture, then of_in=0 capture -> OF=0, of_sticky=1; clr_flags with concurrent overflow capture -> of_sticky=1; clr_flags alone -> 0.
REQ-037 Wrap: 256 result_vld pulses -> capture counter returns to 0, status led bits [7:2]=0.
